pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg_pkg.sv | 24 ++
 rtl/pipe_skid_reg_entry.sv | 49 ++++
 rtl/pipe_skid_reg.sv | 135 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions.
// Holds the bit positions of the control word carried down the pipeline and
// the control value that represents a bubble. Also provides a small helper
// that counts held entries for the stage registers.
package pipe_skid_reg_pkg;

    // Width of the control word at its default configuration.
    localparam int CTRL_W_DEFAULT = 4;

    // Bit positions inside the control word.
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_CSR_WRITE  = 1;
    localparam int CTRL_CSR_RETURN = 2;
    localparam int CTRL_MEM_READ   = 3;

    // A bubble carries no write enables of any kind.
    localparam logic [CTRL_W_DEFAULT-1:0] CTRL_IDLE_DEFAULT = '0;

    // Number of valid entries among the two storage slots.
    function automatic logic [1:0] count_valid(input logic a, input logic b);
        return {1'b0, a} + {1'b0, b};
    endfunction

endpackage

// File: rtl/pipe_skid_reg_entry.sv
// pipe_entry: one storage slot of the skid register.
// A valid bit plus the payload (ctrl, addr, data). 'clear' drops the valid
// bit and wins over 'load'; 'load' captures the incoming payload and sets
// valid. Reset zeroes the whole slot.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   load, clear              slot controls
//   d_ctrl, d_addr, d_data   payload to capture on load
//   valid, ctrl, addr, data  current slot contents
module pipe_entry
    import pipe_skid_reg_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEFAULT,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    // NOTE: the payload is reset as well as the valid bit because the head
    // slot drives out_addr/out_data, which must read zero out of reset.
    // Clearing (flush/drain) only drops valid; the stale payload is harmless.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid <= 1'b0;
            ctrl  <= '0;
            addr  <= '0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= d_ctrl;
            addr  <= d_addr;
            data  <= d_data;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid buffer between pipeline stages.
// The main slot drives the outputs; the skid slot catches the one entry that
// arrives while the downstream stage is stalled. in_ready depends only on
// state, so out_ready never reaches in_ready combinationally.
// Ports:
//   clk, rst                        clock, synchronous active-low reset
//   in_valid, in_ready              upstream handshake
//   in_ctrl, in_addr, in_data       upstream payload
//   flush                           squash every held entry
//   out_valid, out_ready            downstream handshake
//   out_ctrl, out_addr, out_data    head-entry payload (ctrl idles on bubble)
//   occupancy                       number of held entries, 0..2
module pipe_skid_reg
    import pipe_skid_reg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CTRL_W    = 4,
    parameter int                ADDR_W    = 17,
    parameter logic [CTRL_W-1:0] CTRL_IDLE = CTRL_W'(CTRL_IDLE_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_valid;
    logic [CTRL_W-1:0] main_ctrl;
    logic              skid_valid;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [ADDR_W-1:0] skid_addr;
    logic [DATA_W-1:0] skid_data;

    logic in_xfer;
    logic out_xfer;
    logic main_load;
    logic main_clear;
    logic skid_load;
    logic skid_clear;

    logic [CTRL_W-1:0] main_d_ctrl;
    logic [ADDR_W-1:0] main_d_addr;
    logic [DATA_W-1:0] main_d_data;

    assign in_ready = !skid_valid;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = main_valid && out_ready;

    // The skid slot only fills behind a valid main slot, so main is never
    // empty while skid is full. When skid holds an entry it is always older
    // than anything upstream, so it has first claim on main.
    always_comb begin
        main_load   = 1'b0;
        main_clear  = 1'b0;
        skid_load   = 1'b0;
        skid_clear  = 1'b0;
        main_d_ctrl = in_ctrl;
        main_d_addr = in_addr;
        main_d_data = in_data;

        if (skid_valid) begin
            main_d_ctrl = skid_ctrl;
            main_d_addr = skid_addr;
            main_d_data = skid_data;
        end

        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else if (skid_valid) begin
            // Full: upstream is blocked; drain skid into main on a transfer.
            main_load  = out_xfer;
            skid_clear = out_xfer;
        end else if (main_valid) begin
            // One entry: replace, drain, or park the newcomer in skid.
            main_load  = in_xfer && out_xfer;
            main_clear = out_xfer && !in_xfer;
            skid_load  = in_xfer && !out_xfer;
        end else begin
            main_load = in_xfer;
        end
    end

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk    (clk),
        .rst    (rst),
        .load   (main_load),
        .clear  (main_clear),
        .d_ctrl (main_d_ctrl),
        .d_addr (main_d_addr),
        .d_data (main_d_data),
        .valid  (main_valid),
        .ctrl   (main_ctrl),
        .addr   (out_addr),
        .data   (out_data)
    );

    pipe_entry #(
        .CTRL_W (CTRL_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_ctrl (in_ctrl),
        .d_addr (in_addr),
        .d_data (in_data),
        .valid  (skid_valid),
        .ctrl   (skid_ctrl),
        .addr   (skid_addr),
        .data   (skid_data)
    );

    assign out_valid = main_valid;
    // A bubble must never carry write enables downstream.
    assign out_ctrl  = main_valid ? main_ctrl : CTRL_IDLE;
    assign occupancy = count_valid(main_valid, skid_valid);

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios on the default
// configuration, a wide/non-zero-idle instance, and a randomized handshake
// run checked against a queue model.
module tb_pipe_skid_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [16:0] in_addr;
    logic [31:0] in_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_ctrl;
    logic [16:0] out_addr;
    logic [31:0] out_data;
    logic [1:0]  occupancy;

    logic        w_in_valid;
    logic        w_in_ready;
    logic [3:0]  w_in_ctrl;
    logic [16:0] w_in_addr;
    logic [63:0] w_in_data;
    logic        w_out_valid;
    logic        w_out_ready;
    logic [3:0]  w_out_ctrl;
    logic [16:0] w_out_addr;
    logic [63:0] w_out_data;
    logic [1:0]  w_occupancy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_addr   (in_addr),
        .in_data   (in_data),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    pipe_skid_reg #(
        .DATA_W    (64),
        .CTRL_IDLE (4'b1000)
    ) dut_wide (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (w_in_valid),
        .in_ready  (w_in_ready),
        .in_ctrl   (w_in_ctrl),
        .in_addr   (w_in_addr),
        .in_data   (w_in_data),
        .flush     (flush),
        .out_valid (w_out_valid),
        .out_ready (w_out_ready),
        .out_ctrl  (w_out_ctrl),
        .out_addr  (w_out_addr),
        .out_data  (w_out_data),
        .occupancy (w_occupancy)
    );

    // One clock edge; outputs are then inspected and inputs changed on the
    // falling edge, well away from the active edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [16:0] a,
                         input logic [31:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_addr  = a;
        in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
        checks++; if (out_ctrl !== 4'h0) begin failures++; $display("FAIL reset_out_ctrl got %h expected 0", out_ctrl); end
        checks++; if (out_addr !== 17'h0) begin failures++; $display("FAIL reset_out_addr got %h expected 0", out_addr); end
        checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got %h expected 0", out_data); end
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occupancy got %0d expected 0", occupancy); end
        checks++; if (w_out_ctrl !== 4'b1000) begin failures++; $display("FAIL reset_wide_ctrl got %b expected 1000", w_out_ctrl); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 4'h1, 17'(i), 32'(i));
            step();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin failures++; $display("FAIL stream_data[%0d] got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, 32'(i)); end
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL stream_in_ready[%0d] got %b expected 1", i, in_ready); end
            checks++; if (occupancy !== 2'd1) begin failures++; $display("FAIL stream_occupancy[%0d] got %0d expected 1", i, occupancy); end
        end
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        step();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain got v=%b c=%h occ=%0d expected v=0 c=0 occ=0", out_valid, out_ctrl, occupancy); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 17'h0A, 32'hA);
        step();
        checks++; if (out_data !== 32'hA || occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_load_a got d=%h occ=%0d rdy=%b expected d=a occ=1 rdy=1", out_data, occupancy, in_ready); end
        drive(1'b1, 4'h2, 17'h0B, 32'hB);
        step();
        checks++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin failures++; $display("FAIL stall_full got rdy=%b occ=%0d expected rdy=0 occ=2", in_ready, occupancy); end
        checks++; if (out_data !== 32'hA || out_ctrl !== 4'h1 || out_addr !== 17'h0A) begin failures++; $display("FAIL stall_hold_b got d=%h c=%h a=%h expected d=a c=1 a=a", out_data, out_ctrl, out_addr); end
        // Offer C while full, toggling in_valid; nothing may move.
        for (int k = 0; k < 3; k++) begin
            drive(k != 1, 4'h3, 17'h0C, 32'hC);
            step();
            checks++; if (out_data !== 32'hA || out_ctrl !== 4'h1 || out_valid !== 1'b1 || occupancy !== 2'd2 || in_ready !== 1'b0) begin failures++; $display("FAIL stall_hold_c[%0d] got d=%h c=%h v=%b occ=%0d rdy=%b expected d=a c=1 v=1 occ=2 rdy=0", k, out_data, out_ctrl, out_valid, occupancy, in_ready); end
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 32'hB || out_ctrl !== 4'h2 || occupancy !== 2'd1 || in_ready !== 1'b1) begin failures++; $display("FAIL stall_release_b got d=%h c=%h occ=%0d rdy=%b expected d=b c=2 occ=1 rdy=1", out_data, out_ctrl, occupancy, in_ready); end
        step();
        checks++; if (out_data !== 32'hC || out_ctrl !== 4'h3 || occupancy !== 2'd1) begin failures++; $display("FAIL stall_release_c got d=%h c=%h occ=%0d expected d=c c=3 occ=1", out_data, out_ctrl, occupancy); end
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL stall_drain got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 4'h5, 17'h0D, 32'hD);
        step();
        drive(1'b1, 4'h6, 17'h0E, 32'hE);
        step();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL flush_fill got occ=%0d expected 2", occupancy); end
        drive(1'b1, 4'h7, 17'h0F, 32'hF);
        flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0 || in_ready !== 1'b1) begin failures++; $display("FAIL flush_full got v=%b c=%h occ=%0d rdy=%b expected v=0 c=0 occ=0 rdy=1", out_valid, out_ctrl, occupancy, in_ready); end
        flush = 1'b0;
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL flush_no_reappear[%0d] got v=%b occ=%0d d=%h expected v=0 occ=0", k, out_valid, occupancy, out_data); end
        end
        // Flush with one entry held while an input transfer is offered.
        out_ready = 1'b0;
        drive(1'b1, 4'h1, 17'h10, 32'h10);
        step();
        drive(1'b1, 4'h2, 17'h11, 32'h11);
        flush = 1'b1;
        step();
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard_input got occ=%0d v=%b expected occ=0 v=0", occupancy, out_valid); end
        flush = 1'b0;
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_discard_after got v=%b expected 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        drive(1'b1, 4'h4, 17'h1234, 32'h1111_2222);
        step();
        drive(1'b1, 4'h5, 17'h0567, 32'h3333_4444);
        step();
        checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL rstmid_fill got occ=%0d expected 2", occupancy); end
        rst   = 1'b0;
        flush = 1'b1;
        step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ctrl !== 4'h0 || occupancy !== 2'd0) begin failures++; $display("FAIL rstmid_ctl got rdy=%b v=%b c=%h occ=%0d expected rdy=1 v=0 c=0 occ=0", in_ready, out_valid, out_ctrl, occupancy); end
        checks++; if (out_addr !== 17'h0 || out_data !== 32'h0) begin failures++; $display("FAIL rstmid_payload got a=%h d=%h expected a=0 d=0", out_addr, out_data); end
        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin failures++; $display("FAIL rstmid_after got v=%b occ=%0d expected v=0 occ=0", out_valid, occupancy); end
    endtask

    task automatic test_wide();
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_ctrl   = 4'b0011;
        w_in_addr   = 17'h1ABCD;
        w_in_data   = 64'hDEAD_BEEF_0123_4567;
        step();
        checks++; if (w_out_valid !== 1'b1 || w_out_data !== 64'hDEAD_BEEF_0123_4567) begin failures++; $display("FAIL wide_data got v=%b d=%h expected v=1 d=deadbeef01234567", w_out_valid, w_out_data); end
        checks++; if (w_out_ctrl !== 4'b0011 || w_out_addr !== 17'h1ABCD) begin failures++; $display("FAIL wide_ctrl got c=%b a=%h expected c=0011 a=1abcd", w_out_ctrl, w_out_addr); end
        w_in_valid = 1'b0;
        step();
        checks++; if (w_out_valid !== 1'b0 || w_out_ctrl !== 4'b1000 || w_occupancy !== 2'd0) begin failures++; $display("FAIL wide_idle got v=%b c=%b occ=%0d expected v=0 c=1000 occ=0", w_out_valid, w_out_ctrl, w_occupancy); end
    endtask

    task automatic test_random();
        logic [31:0] sb_q[$];
        logic [31:0] seq = 32'h100;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++; if (occupancy !== 2'(sb_q.size())) begin failures++; $display("FAIL rand_occupancy[%0d] got %0d expected %0d", cyc, occupancy, sb_q.size()); end
            checks++; if (in_ready !== (sb_q.size() < 2)) begin failures++; $display("FAIL rand_in_ready[%0d] got %b expected %b", cyc, in_ready, sb_q.size() < 2); end
            if (sb_q.size() > 0) begin
                checks++; if (out_valid !== 1'b1 || out_data !== sb_q[0] || out_ctrl !== sb_q[0][3:0]) begin failures++; $display("FAIL rand_head[%0d] got v=%b d=%h c=%h expected v=1 d=%h c=%h", cyc, out_valid, out_data, out_ctrl, sb_q[0], sb_q[0][3:0]); end
            end else begin
                checks++; if (out_valid !== 1'b0 || out_ctrl !== 4'h0) begin failures++; $display("FAIL rand_empty[%0d] got v=%b c=%h expected v=0 c=0", cyc, out_valid, out_ctrl); end
            end
            drive(1'($urandom_range(0, 1)), seq[3:0], seq[16:0], seq);
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (in_valid && in_ready) begin
                sb_q.push_back(seq);
                seq++;
            end
            step();
        end
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        out_ready = 1'b1;
        step();
        step();
        checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL rand_final_drain got occ=%0d expected 0", occupancy); end
    endtask

    initial begin
        rst         = 1'b0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        w_in_valid  = 1'b0;
        w_in_ctrl   = 4'h0;
        w_in_addr   = 17'h0;
        w_in_data   = 64'h0;
        w_out_ready = 1'b0;
        drive(1'b0, 4'h0, 17'h0, 32'h0);
        @(negedge clk);

        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_reset_mid();
        test_wide();
        test_random();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
